// File: rtl/flash_bank_ctrl.sv
// Clocked flash bank model: read, bit-clearing program, block erase, with busy/done/err reporting.
// Optional write protect input is compiled in when FLASH_WP_EN is defined.
module flash_bank_ctrl #(
  parameter int DATA_W      = 8,
  parameter int BANK_W      = 4,
  parameter int BLOCK_W     = 4,
  parameter int ROW_W       = 8,
  parameter int PROG_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [BANK_W-1:0]  addr_bank,
  input  logic [BLOCK_W-1:0] addr_block,
  input  logic [ROW_W-1:0]   addr_row,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_out,
  output logic               data_valid,
  output logic               busy,
  output logic               op_done,
  output logic               err
`ifdef FLASH_WP_EN
  ,
  input  logic               wp
`endif
);

  localparam int ADDR_W = BANK_W + BLOCK_W + ROW_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_PROG,
    S_ERASE,
    S_FAIL
  } state_e;

  typedef struct packed {
    logic [BANK_W-1:0]  bank;
    logic [BLOCK_W-1:0] block;
    logic [ROW_W-1:0]   row;
    logic [DATA_W-1:0]  data;
  } cmd_t;

  state_e             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               op_done_q, op_done_d;
  logic               err_q, err_d;

  // Storage holds the complement of each word, so the all-zero power-up
  // state of the array reads back as erased (all-ones).
  logic [DATA_W-1:0]  mem_n [DEPTH];
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata_n;

  logic [ADDR_W-1:0]  cmd_addr;
  logic [DATA_W-1:0]  cur_word;
  logic               wp_blk;

`ifdef FLASH_WP_EN
  assign wp_blk = wp;
`else
  assign wp_blk = 1'b0;
`endif

  assign cmd_addr  = {cmd_q.bank, cmd_q.block, cmd_q.row};
  assign cur_word  = ~mem_n[cmd_addr];
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign data_out  = data_out_q;
  assign data_valid = data_valid_q;
  assign op_done   = op_done_q;
  assign err       = err_q;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    row_cnt_d    = row_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    op_done_d    = 1'b0;
    err_d        = err_q;
    mem_we       = 1'b0;
    mem_waddr    = cmd_addr;
    mem_wdata_n  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_d.bank  = addr_bank;
          cmd_d.block = addr_block;
          cmd_d.row   = addr_row;
          cmd_d.data  = data_in;
          err_d       = 1'b0;
          unique case (cmd_op)
            2'b00: state_d = S_READ;
            2'b01: begin
              state_d = wp_blk ? S_FAIL : S_PROG;
              cnt_d   = CNT_W'(PROG_CYCLES - 1);
            end
            2'b10: begin
              state_d   = wp_blk ? S_FAIL : S_ERASE;
              row_cnt_d = '0;
            end
            default: state_d = S_FAIL;
          endcase
        end
      end
      S_READ: begin
        data_out_d   = cur_word;
        data_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      S_PROG: begin
        if (cnt_q == '0) begin
          // Programming can only clear bits; any requested 0->1 is flagged.
          mem_we      = 1'b1;
          mem_wdata_n = mem_n[cmd_addr] | ~cmd_q.data;
          err_d       = |(~cur_word & cmd_q.data);
          op_done_d   = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ERASE: begin
        mem_we      = 1'b1;
        mem_waddr   = {cmd_q.bank, cmd_q.block, row_cnt_q};
        mem_wdata_n = '0;
        row_cnt_d   = row_cnt_q + 1'b1;
        if (row_cnt_q == '1) begin
          op_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_FAIL: begin
        err_d     = 1'b1;
        op_done_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      cnt_q        <= '0;
      row_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      op_done_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      row_cnt_q    <= row_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      op_done_q    <= op_done_d;
      err_q        <= err_d;
    end
  end

  // Non-volatile array: no reset; write enable is gated off while rst holds state in IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) mem_n[mem_waddr] <= mem_wdata_n;
  end

endmodule

// File: tb/tb_flash_bank_ctrl.sv
// Self-checking bench for flash_bank_ctrl against an array-based flash model.
module tb_flash_bank_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] addr_bank = '0;
  logic [3:0] addr_block = '0;
  logic [7:0] addr_row = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       data_valid, busy, op_done, err;
`ifdef FLASH_WP_EN
  logic       wp = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] ref_mem [65536];

  always #5 clk = ~clk;

  flash_bank_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .addr_bank(addr_bank), .addr_block(addr_block), .addr_row(addr_row), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .busy(busy), .op_done(op_done), .err(err)
`ifdef FLASH_WP_EN
    , .wp(wp)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int idx(input logic [3:0] b, input logic [3:0] k, input logic [7:0] r);
    return int'({b, k, r});
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Drives one command through edge E; returns at E+1ns. Inputs are then scrambled
  // to show that values presented while busy do not matter.
  task automatic issue(input logic [1:0] op, input logic [3:0] b, input logic [3:0] k,
                       input logic [7:0] r, input logic [7:0] d, output logic busy0);
    int w = 0;
    while (!cmd_ready && w < 1000) begin tick; w++; end
    cmd_valid = 1'b1; cmd_op = op; addr_bank = b; addr_block = k; addr_row = r; data_in = d;
    tick;
    cmd_valid = 1'b0;
    busy0 = busy;
    cmd_op = 2'($urandom); addr_bank = 4'($urandom); addr_block = 4'($urandom);
    addr_row = 8'($urandom); data_in = 8'($urandom);
  endtask

  // Edges after E until op_done or data_valid, or -1 if none within bound.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      tick;
      if (op_done || data_valid) begin lat = i; break; end
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] b, input logic [3:0] k,
                      input logic [7:0] r, input logic [7:0] d, output int lat, output logic busy0);
    issue(op, b, k, r, d, busy0);
    wait_done(lat);
  endtask

  function automatic logic model_prog(input int a, input logic [7:0] d);
    logic e;
    e = |(~ref_mem[a] & d);
    ref_mem[a] = ref_mem[a] & d;
    return e;
  endfunction

  function automatic void model_erase(input logic [3:0] b, input logic [3:0] k);
    for (int r = 0; r < 256; r++) ref_mem[idx(b, k, 8'(r))] = 8'hFF;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    tick;
    checks += 6;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    if (op_done !== 1'b0) begin errors++; $display("FAIL reset_op_done got=%b exp=0", op_done); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_read;
    int lat; logic b0;
    send(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, lat, b0);
    checks += 5;
    if (lat !== 1) begin errors++; $display("FAIL read_latency got=%0d exp=1", lat); end
    if (data_out !== 8'hFF) begin errors++; $display("FAIL read_erased got=%h exp=ff", data_out); end
    if (err !== 1'b0) begin errors++; $display("FAIL read_err got=%b exp=0", err); end
    if (b0 !== 1'b1) begin errors++; $display("FAIL read_busy got=%b exp=1", b0); end
    tick;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL read_dv_pulse got=%b exp=0", data_valid); end
  endtask

  task automatic test_program;
    int lat; logic b0; logic e;
    e = model_prog(idx(4'd1, 4'd2, 8'h10), 8'hA5);
    send(2'b01, 4'd1, 4'd2, 8'h10, 8'hA5, lat, b0);
    checks += 4;
    if (b0 !== 1'b1) begin errors++; $display("FAIL prog_busy got=%b exp=1", b0); end
    if (lat !== 4) begin errors++; $display("FAIL prog_latency got=%0d exp=4", lat); end
    if (err !== e) begin errors++; $display("FAIL prog_err got=%b exp=%b", err, e); end
    if (busy !== 1'b0) begin errors++; $display("FAIL prog_idle got=%b exp=0", busy); end
    send(2'b00, 4'd1, 4'd2, 8'h10, 8'h00, lat, b0);
    checks++;
    if (data_out !== ref_mem[idx(4'd1, 4'd2, 8'h10)])
      begin errors++; $display("FAIL prog_readback got=%h exp=%h", data_out, ref_mem[idx(4'd1, 4'd2, 8'h10)]); end
    e = model_prog(idx(4'd1, 4'd2, 8'h10), 8'h5A);
    send(2'b01, 4'd1, 4'd2, 8'h10, 8'h5A, lat, b0);
    checks += 2;
    if (lat !== 4) begin errors++; $display("FAIL prog2_latency got=%0d exp=4", lat); end
    if (err !== e) begin errors++; $display("FAIL prog2_err got=%b exp=%b", err, e); end
    send(2'b00, 4'd1, 4'd2, 8'h10, 8'h00, lat, b0);
    checks += 2;
    if (data_out !== ref_mem[idx(4'd1, 4'd2, 8'h10)])
      begin errors++; $display("FAIL prog2_readback got=%h exp=%h", data_out, ref_mem[idx(4'd1, 4'd2, 8'h10)]); end
    if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b exp=0", err); end
  endtask

  task automatic test_erase;
    int lat; logic b0; logic e;
    e = model_prog(idx(4'd1, 4'd3, 8'h22), 8'h3C);
    send(2'b01, 4'd1, 4'd3, 8'h22, 8'h3C, lat, b0);
    model_erase(4'd1, 4'd2);
    send(2'b10, 4'd1, 4'd2, 8'h77, 8'h00, lat, b0);
    checks += 2;
    if (lat !== 256) begin errors++; $display("FAIL erase_latency got=%0d exp=256", lat); end
    if (err !== 1'b0) begin errors++; $display("FAIL erase_err got=%b exp=0", err); end
    send(2'b00, 4'd1, 4'd2, 8'h10, 8'h00, lat, b0);
    checks++;
    if (data_out !== ref_mem[idx(4'd1, 4'd2, 8'h10)])
      begin errors++; $display("FAIL erase_target got=%h exp=%h", data_out, ref_mem[idx(4'd1, 4'd2, 8'h10)]); end
    send(2'b00, 4'd1, 4'd3, 8'h22, 8'h00, lat, b0);
    checks++;
    if (data_out !== ref_mem[idx(4'd1, 4'd3, 8'h22)])
      begin errors++; $display("FAIL erase_neighbour got=%h exp=%h", data_out, ref_mem[idx(4'd1, 4'd3, 8'h22)]); end
  endtask

  task automatic test_reset_mid_erase;
    int lat; logic b0; logic e;
    logic [7:0] rows [5];
    rows[0] = 8'h00; rows[1] = 8'h3F; rows[2] = 8'h40; rows[3] = 8'h41; rows[4] = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      e = model_prog(idx(4'd2, 4'd5, rows[i]), 8'h12 + 8'(i));
      send(2'b01, 4'd2, 4'd5, rows[i], 8'h12 + 8'(i), lat, b0);
    end
    issue(2'b10, 4'd2, 4'd5, 8'h00, 8'h00, b0);
    repeat (64) tick;
    rst = 1'b1;
    for (int r = 0; r < 64; r++) ref_mem[idx(4'd2, 4'd5, 8'(r))] = 8'hFF;
    #2;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready got=%b exp=1", cmd_ready); end
    tick;
    rst = 1'b0;
    tick;
    checks += 3;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_erase_ready got=%b exp=1", cmd_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_erase_busy got=%b exp=0", busy); end
    if (data_out !== 8'h00) begin errors++; $display("FAIL rst_erase_dout got=%h exp=00", data_out); end
    for (int i = 0; i < 5; i++) begin
      send(2'b00, 4'd2, 4'd5, rows[i], 8'h00, lat, b0);
      checks++;
      if (data_out !== ref_mem[idx(4'd2, 4'd5, rows[i])])
        begin errors++; $display("FAIL rst_erase_row%h got=%h exp=%h", rows[i], data_out, ref_mem[idx(4'd2, 4'd5, rows[i])]); end
    end
  endtask

  task automatic test_reset_mid_prog;
    int lat; logic b0;
    issue(2'b01, 4'd3, 4'd3, 8'd3, 8'h00, b0);
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    send(2'b00, 4'd3, 4'd3, 8'd3, 8'h00, lat, b0);
    checks++;
    if (data_out !== ref_mem[idx(4'd3, 4'd3, 8'd3)])
      begin errors++; $display("FAIL rst_prog_nowrite got=%h exp=%h", data_out, ref_mem[idx(4'd3, 4'd3, 8'd3)]); end
  endtask

  task automatic test_illegal;
    int lat; logic b0; logic e;
    e = model_prog(idx(4'd4, 4'd4, 8'd4), 8'hC3);
    send(2'b01, 4'd4, 4'd4, 8'd4, 8'hC3, lat, b0);
    send(2'b11, 4'd4, 4'd4, 8'd4, 8'h00, lat, b0);
    checks += 2;
    if (lat !== 1) begin errors++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
    if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b exp=1", err); end
`ifdef FLASH_WP_EN
    wp = 1'b1;
    send(2'b01, 4'd4, 4'd4, 8'd4, 8'h00, lat, b0);
    checks += 2;
    if (lat !== 1) begin errors++; $display("FAIL wp_prog_latency got=%0d exp=1", lat); end
    if (err !== 1'b1) begin errors++; $display("FAIL wp_prog_err got=%b exp=1", err); end
    send(2'b10, 4'd4, 4'd4, 8'd0, 8'h00, lat, b0);
    checks += 2;
    if (lat !== 1) begin errors++; $display("FAIL wp_erase_latency got=%0d exp=1", lat); end
    if (err !== 1'b1) begin errors++; $display("FAIL wp_erase_err got=%b exp=1", err); end
`endif
    send(2'b00, 4'd4, 4'd4, 8'd4, 8'h00, lat, b0);
    checks += 2;
    if (lat !== 1) begin errors++; $display("FAIL illegal_read_latency got=%0d exp=1", lat); end
    if (data_out !== ref_mem[idx(4'd4, 4'd4, 8'd4)])
      begin errors++; $display("FAIL illegal_mem_kept got=%h exp=%h", data_out, ref_mem[idx(4'd4, 4'd4, 8'd4)]); end
`ifdef FLASH_WP_EN
    wp = 1'b0;
`endif
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    int w = 0;
    while (!cmd_ready && w < 1000) begin tick; w++; end
    cmd_valid = 1'b1; cmd_op = 2'b00; addr_bank = 4'd1; addr_block = 4'd3; addr_row = 8'h22;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (data_valid) begin
        pulses++;
        checks++;
        if (data_out !== ref_mem[idx(4'd1, 4'd3, 8'h22)])
          begin errors++; $display("FAIL b2b_data got=%h exp=%h", data_out, ref_mem[idx(4'd1, 4'd3, 8'h22)]); end
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (pulses !== 5) begin errors++; $display("FAIL b2b_pulses got=%0d exp=5", pulses); end
  endtask

  task automatic test_random;
    int lat; logic b0; logic e; int sel; int a;
    logic [3:0] b, k; logic [7:0] r, d;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      b = 4'($urandom_range(0, 3)); k = 4'($urandom_range(0, 1));
      r = 8'($urandom_range(0, 3)); d = 8'($urandom);
      a = idx(b, k, r);
      if (sel < 4) begin
        send(2'b00, b, k, r, d, lat, b0);
        checks += 3;
        if (lat !== 1) begin errors++; $display("FAIL rnd_read_lat n=%0d got=%0d exp=1", n, lat); end
        if (data_out !== ref_mem[a]) begin errors++; $display("FAIL rnd_read n=%0d got=%h exp=%h", n, data_out, ref_mem[a]); end
        if (err !== 1'b0) begin errors++; $display("FAIL rnd_read_err n=%0d got=%b exp=0", n, err); end
      end else if (sel < 8) begin
        e = model_prog(a, d);
        send(2'b01, b, k, r, d, lat, b0);
        checks += 2;
        if (lat !== 4) begin errors++; $display("FAIL rnd_prog_lat n=%0d got=%0d exp=4", n, lat); end
        if (err !== e) begin errors++; $display("FAIL rnd_prog_err n=%0d got=%b exp=%b", n, err, e); end
      end else if (sel == 8) begin
        model_erase(b, k);
        send(2'b10, b, k, r, d, lat, b0);
        checks += 2;
        if (lat !== 256) begin errors++; $display("FAIL rnd_erase_lat n=%0d got=%0d exp=256", n, lat); end
        if (err !== 1'b0) begin errors++; $display("FAIL rnd_erase_err n=%0d got=%b exp=0", n, err); end
      end else begin
        send(2'b11, b, k, r, d, lat, b0);
        checks += 2;
        if (lat !== 1) begin errors++; $display("FAIL rnd_ill_lat n=%0d got=%0d exp=1", n, lat); end
        if (err !== 1'b1) begin errors++; $display("FAIL rnd_ill_err n=%0d got=%b exp=1", n, err); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'hFF;
    test_reset;
    test_read;
    test_program;
    test_erase;
    test_reset_mid_erase;
    test_reset_mid_prog;
    test_illegal;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/flash_bank_ctrl.md
# flash_bank_ctrl

- Clocked, parametrised flash memory bank that replaces the level-triggered bank model.
- Storage is addressed by {bank, block, row}. Commands use a valid/ready handshake.
- Models flash semantics: read, multi-cycle program that can only clear bits (1→0), and multi-cycle block erase back to all-ones. Reports busy, done and error.
- Sits behind the I2C slave command decoder as the storage back end.

## Interface
Parameters:
- DATA_W, 8, word width in bits.
- BANK_W, 4, bank address width; bank count is 2^BANK_W.
- BLOCK_W, 4, block address width; block count is 2^BLOCK_W.
- ROW_W, 8, row address width; rows per block is 2^ROW_W.
- PROG_CYCLES, 4, busy cycles per program operation; must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_op  in  2  00 read, 01 program, 10 block erase, 11 illegal.
- addr_bank  in  BANK_W  bank address.
- addr_block  in  BLOCK_W  block address.
- addr_row  in  ROW_W  row address; ignored for erase.
- data_in  in  DATA_W  program data.
- data_out  out  DATA_W  read data; holds its value until the next read completes.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- busy  out  1  high in any state other than IDLE.
- op_done  out  1  one-cycle pulse when a program, erase or illegal command completes.
- err  out  1  error flag; cleared on every accepted command.
- wp  in  1  write protect; present only when FLASH_WP_EN is defined.

## Operation
States and transitions:
- IDLE: on accept, latch op, address and data_in, clear err, then go to:
  - READ for op 00,
  - PROG for op 01, loading cnt = PROG_CYCLES-1,
  - ERASE for op 10, loading row_cnt = 0,
  - FAIL for op 11.
- READ: data_out <= mem[addr]; data_valid <= 1; go to IDLE.
- PROG: decrement cnt each cycle. At cnt == 0:
  - write mem[addr] <= mem[addr] & data_latched;
  - set err if (~mem[addr] & data_latched) != 0, i.e. the command attempted a 0→1 bit;
  - pulse op_done and go to IDLE.
- ERASE: each cycle write mem[{bank, block, row_cnt}] <= all-ones and increment row_cnt. After the row 2^ROW_W-1 write, pulse op_done and go to IDLE.
- FAIL: set err, pulse op_done, go to IDLE.

Memory rules:
- Memory is 2^(BANK_W+BLOCK_W+ROW_W) words, initialised to all-ones at time zero.
- rst does not alter memory contents (non-volatile).
- Erase touches only the addressed block; other blocks and banks are unchanged.

Reset:
- Outputs after reset: state IDLE, cmd_ready 1, busy 0, data_out 0, data_valid 0, op_done 0, err 0; counters cleared.
- Reset during PROG: no write occurs.
- Reset during ERASE: rows already erased stay all-ones; the remaining rows are unchanged.

Address and input rules:
- All address combinations are legal; there is no wrap or out-of-range case.
- Inputs sampled while busy are ignored; cmd_valid held high simply waits.

## Timing
Command accepted on edge E:
- Read: data_out and data_valid update on E+1. cmd_ready returns after E+1, so the read throughput is one every 2 cycles.
- Program: busy from E to E+PROG_CYCLES. The write and op_done occur on edge E+PROG_CYCLES.
- Erase: the row writes occur on edges E+1 … E+2^ROW_W. op_done occurs on edge E+2^ROW_W.
- Illegal: err and op_done set on E+1.

Output behaviour:
- All outputs are registered.
- cmd_ready = (state == IDLE) and is combinational from state only.
- err persists until the next accepted command.

## Configuration
FLASH_WP_EN:
- Defined: adds the wp port, sampled at accept. Program or erase accepted with wp == 1 goes to FAIL: memory unchanged, err 1 and op_done on E+1. Reads are unaffected.
- Undefined: no wp port; all program and erase commands proceed.

## Test plan
- Reset, then read {0,0,0} → data_valid on E+1, data_out 0xFF, err 0.
- Program {1,2,0x10} with 0xA5 → busy for 4 cycles, op_done on E+4; read back gives 0xA5.
- Program the same address with 0x5A → read gives 0x00; err 1 after op_done.
- Erase block {1,2} → op_done on E+256; {1,2,0x10} reads 0xFF; a word pre-programmed in {1,3} keeps its value.
- Assert rst mid-erase at row 0x40 → rows 0x00–0x3F read 0xFF, rows ≥0x40 keep their old data; cmd_ready 1 after release.
- cmd_op 11 → err 1 and op_done on E+1, memory unchanged. With FLASH_WP_EN and wp = 1, a program command gives the same response.
